// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types for the MM:SS BCD countdown timer: digit type, FSM state
// encoding and the packed four-digit layout used on the display bus.
package bcd_timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef struct packed {
    bcd_digit_t min_t;
    bcd_digit_t min_o;
    bcd_digit_t sec_t;
    bcd_digit_t sec_o;
  } bcd_time_t;

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Command/status bundle between the timer and its controller: strobes in,
// BCD digits and status flags out.
interface bcd_countdown_timer_if;

  logic        tick_en;
  logic        load;
  logic [15:0] load_bcd;
  logic        start;
  logic        pause;
  logic        clear;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        done_pulse;
  logic        load_err;

  modport master (
    output tick_en, load, load_bcd, start, pause, clear,
    input  digits, running, expired, done_pulse, load_err
  );

  modport slave (
    input  tick_en, load, load_bcd, start, pause, clear,
    output digits, running, expired, done_pulse, load_err
  );

endinterface

// File: rtl/bcd_countdown_timer_digit_dec.sv
// One stage of the BCD borrow chain: decrements a digit when a borrow comes
// in, wrapping to wrap_i and passing the borrow on when the digit is zero.
module bcd_digit_dec
  import bcd_timer_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       borrow_i,
  input  bcd_digit_t wrap_i,
  output bcd_digit_t digit_o,
  output logic       borrow_o
);

  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == 4'd0) begin
        digit_o  = wrap_i;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer stepped by a 1 Hz enable pulse. Optional macro
// BCD_TIMER_AUTO_RELOAD_EN reloads the last accepted load value on expiry.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = 9,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_countdown_timer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_PAUSED = PAUSED;
  localparam logic [1:0] ST_DONE   = DONE;

  localparam bcd_digit_t MIN_T_MAX = bcd_digit_t'(MIN_TENS_MAX);
  localparam bcd_digit_t SEC_T_MAX = bcd_digit_t'(SEC_TENS_MAX);

  logic [1:0] state_q, state_d;
  bcd_time_t  digits_q, digits_d, dec_digits, load_val;
  logic       running_q, expired_q, done_q, done_d, lerr_q, lerr_d;
  logic       b_sec_o, b_sec_t, b_min_o, b_min_t;
  logic       count_nz, load_ok;

  assign load_val = bcd_time_t'(bus.load_bcd);

  function automatic logic load_valid(input bcd_time_t v);
    return (v.sec_o <= BCD_MAX) && (v.sec_t <= BCD_MAX) &&
           (v.min_o <= BCD_MAX) && (v.min_t <= BCD_MAX) &&
           (v.min_t <= MIN_T_MAX) && (v.sec_t <= SEC_T_MAX);
  endfunction

  assign load_ok = load_valid(load_val);

  bcd_digit_dec u_sec_o (.digit_i(digits_q.sec_o), .borrow_i(1'b1), .wrap_i(BCD_MAX),
                         .digit_o(dec_digits.sec_o), .borrow_o(b_sec_o));
  bcd_digit_dec u_sec_t (.digit_i(digits_q.sec_t), .borrow_i(b_sec_o), .wrap_i(SEC_T_MAX),
                         .digit_o(dec_digits.sec_t), .borrow_o(b_sec_t));
  bcd_digit_dec u_min_o (.digit_i(digits_q.min_o), .borrow_i(b_sec_t), .wrap_i(BCD_MAX),
                         .digit_o(dec_digits.min_o), .borrow_o(b_min_o));
  bcd_digit_dec u_min_t (.digit_i(digits_q.min_t), .borrow_i(b_min_o), .wrap_i(BCD_MAX),
                         .digit_o(dec_digits.min_t), .borrow_o(b_min_t));

  // A borrow escaping the top digit means the count was already 00:00.
  assign count_nz = ~b_min_t;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  bcd_time_t reload_q, reload_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reload_q <= '0;
    else        reload_q <= reload_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    lerr_d   = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.clear) begin
      digits_d = '0;
      state_d  = ST_IDLE;
    end else if (bus.load && (state_q != ST_RUN)) begin
      if (load_ok) begin
        digits_d = load_val;
        state_d  = ST_IDLE;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        reload_d = load_val;
`endif
      end else begin
        lerr_d = 1'b1;
      end
    end else if (bus.start && count_nz &&
                 ((state_q == ST_IDLE) || (state_q == ST_PAUSED))) begin
      state_d = ST_RUN;
    end else if (bus.pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSED;
    end else if (bus.tick_en && (state_q == ST_RUN) && count_nz) begin
      digits_d = dec_digits;
      if (dec_digits == '0) begin
        done_d  = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        if (reload_q != '0) digits_d = reload_q;
        else                state_d  = ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      digits_q  <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
      lerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_DONE);
      done_q    <= done_d;
      lerr_q    <= lerr_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.running    = running_q;
  assign bus.expired    = expired_q;
  assign bus.done_pulse = done_q;
  assign bus.load_err   = lerr_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer; auto-reload scenario runs when
// BCD_TIMER_AUTO_RELOAD_EN is defined.
module tb_bcd_countdown_timer;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer #(.MIN_TENS_MAX(9), .SEC_TENS_MAX(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load_bcd = v;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick_en = 1'b1;
    step();
    bus.tick_en = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    do_load(16'h0130);
    do_start();
    compared++;
    if (bus.running !== 1'b1) begin
      mismatched++; $display("FAIL reset_pre_running: got %b expected 1", bus.running);
    end
    rst_n = 1'b0;
    step();
    compared++;
    if (bus.digits !== 16'h0000) begin
      mismatched++; $display("FAIL reset_digits: got %h expected 0000", bus.digits);
    end
    compared++;
    if ({bus.running, bus.expired, bus.done_pulse, bus.load_err} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.running, bus.expired, bus.done_pulse, bus.load_err});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_borrow();
    logic [15:0] exp_d [3] = '{16'h0101, 16'h0100, 16'h0059};
    do_load(16'h0102);
    compared++;
    if (bus.digits !== 16'h0102 || bus.running !== 1'b0) begin
      mismatched++; $display("FAIL load_0102: got %h/%b expected 0102/0", bus.digits, bus.running);
    end
    do_start();
    bus.tick_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (bus.digits !== exp_d[i] || bus.done_pulse !== 1'b0 || bus.running !== 1'b1) begin
        mismatched++;
        $display("FAIL borrow_tick%0d: got %h done=%b run=%b expected %h done=0 run=1",
                 i, bus.digits, bus.done_pulse, bus.running, exp_d[i]);
      end
    end
    bus.tick_en = 1'b0;
  endtask

  task automatic test_expire();
    do_clear();
    do_load(16'h0002);
    do_start();
    do_tick();
    compared++;
    if (bus.digits !== 16'h0001 || bus.done_pulse !== 1'b0) begin
      mismatched++; $display("FAIL expire_t1: got %h done=%b expected 0001 done=0", bus.digits, bus.done_pulse);
    end
    do_tick();
    compared++;
    if ({bus.digits, bus.done_pulse, bus.expired, bus.running} !== {16'h0000, 3'b110}) begin
      mismatched++;
      $display("FAIL expire_t2: got %h done=%b exp=%b run=%b expected 0000 1 1 0",
               bus.digits, bus.done_pulse, bus.expired, bus.running);
    end
    do_tick();
    compared++;
    if ({bus.digits, bus.done_pulse, bus.expired} !== {16'h0000, 2'b01}) begin
      mismatched++;
      $display("FAIL expire_hold: got %h done=%b exp=%b expected 0000 0 1",
               bus.digits, bus.done_pulse, bus.expired);
    end
    do_start();
    compared++;
    if (bus.running !== 1'b0 || bus.expired !== 1'b1) begin
      mismatched++; $display("FAIL expire_start: got run=%b exp=%b expected 0 1", bus.running, bus.expired);
    end
  endtask

  task automatic test_load_err();
    do_load(16'h0060);
    compared++;
    if (bus.load_err !== 1'b1 || bus.digits !== 16'h0000) begin
      mismatched++; $display("FAIL load_sec_t: got err=%b %h expected 1 0000", bus.load_err, bus.digits);
    end
    step();
    compared++;
    if (bus.load_err !== 1'b0) begin
      mismatched++; $display("FAIL load_err_pulse: got %b expected 0", bus.load_err);
    end
    do_load(16'h0A00);
    compared++;
    if (bus.load_err !== 1'b1 || bus.digits !== 16'h0000) begin
      mismatched++; $display("FAIL load_min_o: got err=%b %h expected 1 0000", bus.load_err, bus.digits);
    end
    do_load(16'h0005);
    compared++;
    if (bus.load_err !== 1'b0 || bus.digits !== 16'h0005 || bus.expired !== 1'b0) begin
      mismatched++;
      $display("FAIL load_from_done: got err=%b %h exp=%b expected 0 0005 0", bus.load_err, bus.digits, bus.expired);
    end
    do_start();
    do_load(16'h0003);
    compared++;
    if (bus.load_err !== 1'b0 || bus.digits !== 16'h0005 || bus.running !== 1'b1) begin
      mismatched++;
      $display("FAIL load_in_run: got err=%b %h run=%b expected 0 0005 1", bus.load_err, bus.digits, bus.running);
    end
  endtask

  task automatic test_tick_collide();
    do_clear();
    compared++;
    if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin
      mismatched++; $display("FAIL clear_run: got %h run=%b expected 0000 0", bus.digits, bus.running);
    end
    do_start();
    compared++;
    if (bus.running !== 1'b0) begin
      mismatched++; $display("FAIL start_zero: got run=%b expected 0", bus.running);
    end
    do_load(16'h0010);
    do_start();
    bus.pause = 1'b1; bus.tick_en = 1'b1;
    step();
    bus.pause = 1'b0; bus.tick_en = 1'b0;
    compared++;
    if (bus.running !== 1'b0 || bus.digits !== 16'h0010) begin
      mismatched++; $display("FAIL pause_tick: got run=%b %h expected 0 0010", bus.running, bus.digits);
    end
    do_tick();
    compared++;
    if (bus.digits !== 16'h0010) begin
      mismatched++; $display("FAIL tick_paused: got %h expected 0010", bus.digits);
    end
    bus.start = 1'b1; bus.tick_en = 1'b1;
    step();
    bus.start = 1'b0; bus.tick_en = 1'b0;
    compared++;
    if (bus.running !== 1'b1 || bus.digits !== 16'h0010) begin
      mismatched++; $display("FAIL start_tick: got run=%b %h expected 1 0010", bus.running, bus.digits);
    end
    do_tick();
    compared++;
    if (bus.digits !== 16'h0009) begin
      mismatched++; $display("FAIL resume_tick: got %h expected 0009", bus.digits);
    end
  endtask

  task automatic test_minute_borrow();
    do_clear();
    do_load(16'h1000);
    do_start();
    do_tick();
    compared++;
    if (bus.digits !== 16'h0959) begin
      mismatched++; $display("FAIL minute_borrow: got %h expected 0959", bus.digits);
    end
  endtask

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    do_clear();
    do_load(16'h0002);
    do_start();
    do_tick();
    do_tick();
    compared++;
    if ({bus.digits, bus.done_pulse, bus.running, bus.expired} !== {16'h0002, 3'b110}) begin
      mismatched++;
      $display("FAIL auto_reload: got %h done=%b run=%b exp=%b expected 0002 1 1 0",
               bus.digits, bus.done_pulse, bus.running, bus.expired);
    end
    do_clear();
    compared++;
    if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin
      mismatched++; $display("FAIL auto_clear: got %h run=%b expected 0000 0", bus.digits, bus.running);
    end
  endtask
`endif

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    bus.tick_en  = 1'b0;
    bus.load     = 1'b0;
    bus.load_bcd = 16'h0000;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.clear    = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_borrow();
    test_expire();
    test_load_err();
    test_tick_collide();
    test_minute_borrow();
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
